// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state encodings, opcode/funct constants and ALU codes for the multicycle MIPS controller (addi support keyed on MC_CTRL_ADDI_EN)
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  function automatic logic op_legal(input logic [5:0] op);
`ifdef MC_CTRL_ADDI_EN
    return op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI};
`else
    return op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J};
`endif
  endfunction
endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: maps ALU operation class and funct onto the 3-bit ALU control code
module mc_aludec
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);
  logic [2:0] fdec;
  // unknown funct falls back to add so the instruction still writes back
  always_comb begin
    fdec = funct == F_SUB ? ALU_SUB :
           funct == F_AND ? ALU_AND :
           funct == F_OR  ? ALU_OR  :
           funct == F_SLT ? ALU_SLT : ALU_ADD;
    alucontrol = aluop == ALUOP_SUB   ? ALU_SUB :
                 aluop == ALUOP_FUNCT ? fdec    : ALU_ADD;
  end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS Moore control FSM; addi states exist only with MC_CTRL_ADDI_EN
module mc_controller
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);
  state_t     state, next;
  logic       pcwrite, branch, irw, mw, rw, ill;
  logic [1:0] aluop;
  // state register; reset jumps straight to FETCH without waiting for a clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else state <= next;
  end
  // next-state decode; unused encodings return to FETCH
  always_comb begin
    next = FETCH;
    case (state)
      FETCH: next = DECODE;
      DECODE:
        case (op)
          OP_LW, OP_SW: next = MEMADR;
          OP_RTYPE:     next = RTYPEEX;
          OP_BEQ:       next = BEQEX;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:      next = ADDIEX;
`endif
          OP_J:         next = JEX;
          default:      next = FETCH;
        endcase
      MEMADR:  next = op == OP_SW ? MEMWR : MEMRD;
      MEMRD:   next = MEMWB;
      RTYPEEX: next = RTYPEWB;
`ifdef MC_CTRL_ADDI_EN
      ADDIEX:  next = ADDIWB;
`endif
      default: next = FETCH;
    endcase
  end
  // Moore output decode; unlisted signals stay 0 and aluop defaults to add
  always_comb begin
    pcwrite = 1'b0;
    branch = 1'b0;
    irw = 1'b0;
    mw = 1'b0;
    rw = 1'b0;
    ill = 1'b0;
    iord = 1'b0;
    memtoreg = 1'b0;
    regdst = 1'b0;
    alusrca = 1'b0;
    alusrcb = 2'b00;
    pcsrc = 2'b00;
    aluop = ALUOP_ADD;
    case (state)
      FETCH: begin
        alusrcb = 2'b01;
        irw = 1'b1;
        pcwrite = 1'b1;
      end
      DECODE: begin
        alusrcb = 2'b11;
        ill = !op_legal(op);
      end
`ifdef MC_CTRL_ADDI_EN
      MEMADR, ADDIEX: begin
`else
      MEMADR: begin
`endif
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        rw = 1'b1;
      end
      MEMWR: begin
        iord = 1'b1;
        mw = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        regdst = 1'b1;
        rw = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop = ALUOP_SUB;
        pcsrc = 2'b01;
        branch = 1'b1;
      end
`ifdef MC_CTRL_ADDI_EN
      ADDIWB: rw = 1'b1;
`endif
      JEX: begin
        pcsrc = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end
  // enables are held off while reset is high so no partial write can slip out
  assign pcen     = !reset && (pcwrite || (branch && zero));
  assign irwrite  = !reset && irw;
  assign memwrite = !reset && mw;
  assign regwrite = !reset && rw;
  assign illegal  = !reset && ill;
  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: per-instruction expected output sequences checked every cycle, plus literal pins
module tb_mc_controller;
  typedef struct packed {
    logic       pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
  } rec_t;
  logic clk = 1'b0, reset = 1'b0, zero = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  rec_t act, exp;
  rec_t q[$];
  bit exp_valid = 1'b0;
  string tag = "init";
  int cyc = 0;
  int checks = 0, fails = 0;
  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal)
  );
  assign act = {pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca,
                alusrcb, pcsrc, alucontrol, illegal};
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (act !== exp) begin
        fails++;
        $display("FAIL %s step=%0d got=%h exp=%h", tag, cyc, act, exp);
      end
    end
  end
  function automatic rec_t base();
    rec_t r = '0;
    r.alucontrol = 3'b010;
    return r;
  endfunction
  function automatic logic [2:0] rdec(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction
  task automatic build(input logic [5:0] o, input logic [5:0] f, input logic z);
    rec_t r;
    q.delete();
    r = base(); r.irwrite = 1; r.pcen = 1; r.alusrcb = 2'b01; q.push_back(r);
    r = base(); r.alusrcb = 2'b11;
    case (o)
      6'b100011, 6'b101011: begin
        q.push_back(r);
        r = base(); r.alusrca = 1; r.alusrcb = 2'b10; q.push_back(r);
        if (o == 6'b100011) begin
          r = base(); r.iord = 1; q.push_back(r);
          r = base(); r.memtoreg = 1; r.regwrite = 1; q.push_back(r);
        end else begin
          r = base(); r.iord = 1; r.memwrite = 1; q.push_back(r);
        end
      end
      6'b000000: begin
        q.push_back(r);
        r = base(); r.alusrca = 1; r.alucontrol = rdec(f); q.push_back(r);
        r = base(); r.regdst = 1; r.regwrite = 1; q.push_back(r);
      end
      6'b000100: begin
        q.push_back(r);
        r = base(); r.alusrca = 1; r.pcsrc = 2'b01; r.alucontrol = 3'b110; r.pcen = z; q.push_back(r);
      end
      6'b000010: begin
        q.push_back(r);
        r = base(); r.pcsrc = 2'b10; r.pcen = 1; q.push_back(r);
      end
`ifdef MC_CTRL_ADDI_EN
      6'b001000: begin
        q.push_back(r);
        r = base(); r.alusrca = 1; r.alusrcb = 2'b10; q.push_back(r);
        r = base(); r.regwrite = 1; q.push_back(r);
      end
`endif
      default: begin
        r.illegal = 1; q.push_back(r);
      end
    endcase
  endtask
  task automatic lit(input string n, input rec_t v);
    checks++;
    if (act !== v) begin
      fails++;
      $display("FAIL lit_%s got=%h exp=%h", n, act, v);
    end
  endtask
  task automatic run(input string n, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input int li, input rec_t lv);
    build(o, f, z);
    op = o; funct = f; zero = z; tag = n;
    foreach (q[i]) begin
      exp = q[i]; cyc = i; exp_valid = 1'b1;
      @(negedge clk); #1;
      if (i == li) lit(n, lv);
      @(posedge clk); #1;
    end
  endtask
  logic [5:0] fl[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
  initial begin
    #2 reset = 1'b1;
    exp = 16'h0044; exp_valid = 1'b1; tag = "reset_hold";
    @(posedge clk); #1;
    lit("reset_hold", 16'h0044);
    @(posedge clk); #1;
    reset = 1'b0;
    run("lw", 6'b100011, 6'b0, 1'b1, 4, 16'h1404);
    foreach (fl[k]) run($sformatf("rtype_%b", fl[k]), 6'b000000, fl[k], 1'b1,
                        fl[k] == 6'b101010 ? 2 : -1, 16'h010E);
    run("beq_taken", 6'b000100, 6'b0, 1'b1, 2, 16'h811C);
    run("beq_not", 6'b000100, 6'b0, 1'b0, -1, 16'h0);
    run("j", 6'b000010, 6'b0, 1'b1, 2, 16'h8024);
    run("illegal", 6'b111111, 6'b0, 1'b1, 1, 16'h00C5);
`ifdef MC_CTRL_ADDI_EN
    run("addi", 6'b001000, 6'b0, 1'b1, -1, 16'h0);
`else
    run("addi_illegal", 6'b001000, 6'b0, 1'b1, 1, 16'h00C5);
`endif
    build(6'b101011, 6'b0, 1'b1);
    op = 6'b101011; funct = 6'b0; zero = 1'b1; tag = "sw_cut";
    for (int i = 0; i < 4; i++) begin
      exp = q[i]; cyc = i;
      @(negedge clk); #1;
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    reset = 1'b1;
    exp = 16'h0044; tag = "in_reset";
    #1 lit("memwrite_async_drop", 16'h0044);
    @(negedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    run("sw_after_reset", 6'b101011, 6'b0, 1'b0, 0, 16'hC044);
    run("tail_fetch", 6'b000010, 6'b0, 1'b0, 0, 16'hC044);
    exp_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
